// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: PC drives Instr_Addr, fetched word lands in IF/ID one edge later; freezes on END (3'b111).
// Obeys stall enables and EX branch flush; optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int          PC_W     = 10,
  parameter int          INSTR_W  = 24,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_WriteEn,
  input  logic               IFID_WriteEn,
  input  logic               Branch_Taken,
  input  logic [PC_W-1:0]    Branch_Target,
  input  logic [INSTR_W-1:0] Instr_In,
  output logic [PC_W-1:0]    Instr_Addr,
  output logic [INSTR_W-1:0] IFID_Instr,
  output logic [PC_W-1:0]    IFID_PC1,
  output logic               IFID_Valid,
  output logic               Halted,
  output logic [31:0]        Fetch_Count,
  output logic [31:0]        Stall_Count
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               end_op;
  logic               ifid_load;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    pc_inc    = pc_q + PC_W'(1);
    end_op    = (Instr_In[INSTR_W-1 -: 3] == 3'b111);
    ifid_load = 1'b0;
    state_d   = state_q;
    pc_d      = pc_q;
    pc1_d     = pc1_q;
    instr_d   = instr_q;
    valid_d   = valid_q;

    if (Branch_Taken) begin
      // Redirect wins over stalls and also pulls a wrong-path END out of HALT.
      pc_d    = Branch_Target;
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (IFID_WriteEn) begin
        ifid_load = 1'b1;
        instr_d   = Instr_In;
        pc1_d     = pc_inc;
        valid_d   = 1'b1;
        if (end_op) state_d = ST_HALT;
      end
      if (PC_WriteEn && !(IFID_WriteEn && end_op)) pc_d = pc_inc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_RUN) begin
      if (ifid_load) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (!Branch_Taken && !PC_WriteEn) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= PC_W'(RESET_PC);
      pc1_q       <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc1_q       <= pc1_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign Instr_Addr = pc_q;
  assign IFID_Instr = instr_q;
  assign IFID_PC1   = pc1_q;
  assign IFID_Valid = valid_q;
  assign Halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  assign Fetch_Count = fetch_cnt_q;
  assign Stall_Count = stall_cnt_q;
`else
  assign Fetch_Count = '0;
  assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed fetch_stage bench: driver pushes hand-computed post-edge state, monitor pops and compares after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_WriteEn = 1'b1;
  logic        IFID_WriteEn = 1'b1;
  logic        Branch_Taken = 1'b0;
  logic [9:0]  Branch_Target = '0;
  logic [23:0] Instr_In;
  logic [9:0]  Instr_Addr;
  logic [23:0] IFID_Instr;
  logic [9:0]  IFID_PC1;
  logic        IFID_Valid;
  logic        Halted;
  logic [31:0] Fetch_Count;
  logic [31:0] Stall_Count;
  logic        mem_halt = 1'b0;

  int tests  = 0;
  int failed = 0;
  int idx    = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [23:0] instr;
    logic [9:0]  pc1;
    logic        valid;
    logic        halt;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Instruction memory: word a holds a+1; with mem_halt set, word 3 is an END.
  assign Instr_In = (mem_halt && Instr_Addr == 10'd3) ? 24'hE00003 : 24'(Instr_Addr) + 24'd1;

  fetch_stage #(.PC_W(10), .INSTR_W(24), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_WriteEn   (PC_WriteEn),
    .IFID_WriteEn (IFID_WriteEn),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Instr_In     (Instr_In),
    .Instr_Addr   (Instr_Addr),
    .IFID_Instr   (IFID_Instr),
    .IFID_PC1     (IFID_PC1),
    .IFID_Valid   (IFID_Valid),
    .Halted       (Halted),
    .Fetch_Count  (Fetch_Count),
    .Stall_Count  (Stall_Count)
  );

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic pw, input logic iw, input logic br,
                      input logic [9:0] tgt, input logic [9:0] ea, input logic [23:0] ei,
                      input logic [9:0] ep, input logic ev, input logic eh,
                      input int efc, input int esc);
    exp_t e;
    @(negedge clk);
    reset         = r;
    PC_WriteEn    = pw;
    IFID_WriteEn  = iw;
    Branch_Taken  = br;
    Branch_Target = tgt;
    e.addr  = ea;
    e.instr = ei;
    e.pc1   = ep;
    e.valid = ev;
    e.halt  = eh;
`ifdef FETCH_PERF_CNT_EN
    e.fc = 32'(efc);
    e.sc = 32'(esc);
`else
    e.fc = 32'd0;
    e.sc = 32'd0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: one expectation per edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        idx++;
        chk("instr_addr",  idx, 32'(Instr_Addr), 32'(e.addr));
        chk("ifid_instr",  idx, 32'(IFID_Instr), 32'(e.instr));
        chk("ifid_pc1",    idx, 32'(IFID_PC1),   32'(e.pc1));
        chk("ifid_valid",  idx, 32'(IFID_Valid), 32'(e.valid));
        chk("halted",      idx, 32'(Halted),     32'(e.halt));
        chk("fetch_count", idx, Fetch_Count,     e.fc);
        chk("stall_count", idx, Stall_Count,     e.sc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst pw iw br tgt | addr instr pc1 valid halt | fc sc
    step(1,1,1,0,10'h000, 10'h000,24'h000000,10'h000,0,0, 0,0);
    step(1,1,1,0,10'h000, 10'h000,24'h000000,10'h000,0,0, 0,0);
    step(0,1,1,0,10'h000, 10'h001,24'h000001,10'h001,1,0, 1,0);
    step(0,1,1,0,10'h000, 10'h002,24'h000002,10'h002,1,0, 2,0);
    step(0,1,1,0,10'h000, 10'h003,24'h000003,10'h003,1,0, 3,0);
    step(0,1,1,0,10'h000, 10'h004,24'h000004,10'h004,1,0, 4,0);
    step(0,1,1,0,10'h000, 10'h005,24'h000005,10'h005,1,0, 5,0);
    // two-cycle stall at PC=5
    step(0,0,0,0,10'h000, 10'h005,24'h000005,10'h005,1,0, 5,1);
    step(0,0,0,0,10'h000, 10'h005,24'h000005,10'h005,1,0, 5,2);
    step(0,1,1,0,10'h000, 10'h006,24'h000006,10'h006,1,0, 6,2);
    step(0,1,1,0,10'h000, 10'h007,24'h000007,10'h007,1,0, 7,2);
    step(0,1,1,0,10'h000, 10'h008,24'h000008,10'h008,1,0, 8,2);
    // branch beats a simultaneous stall
    step(0,0,0,1,10'h040, 10'h040,24'h000000,10'h000,0,0, 8,2);
    step(0,1,1,0,10'h000, 10'h041,24'h000041,10'h041,1,0, 9,2);
    // PC wrap at all-ones
    step(0,1,1,1,10'h3FF, 10'h3FF,24'h000000,10'h000,0,0, 9,2);
    step(0,1,1,0,10'h000, 10'h000,24'h000400,10'h000,1,0, 10,2);
    // independent enables
    step(0,1,0,0,10'h000, 10'h001,24'h000400,10'h000,1,0, 10,2);
    step(0,0,1,0,10'h000, 10'h001,24'h000002,10'h002,1,0, 11,3);
    // END at word 3
    mem_halt = 1'b1;
    step(0,1,1,0,10'h000, 10'h002,24'h000002,10'h002,1,0, 12,3);
    step(0,1,1,0,10'h000, 10'h003,24'h000003,10'h003,1,0, 13,3);
    step(0,1,1,0,10'h000, 10'h003,24'hE00003,10'h004,1,1, 14,3);
    for (int i = 0; i < 10; i++)
      step(0,1,1,0,10'h000, 10'h003,24'hE00003,10'h004,1,1, 14,3);
    // wrong-path END: branch leaves HALT
    step(0,1,1,1,10'h010, 10'h010,24'h000000,10'h000,0,0, 14,3);
    step(0,1,1,1,10'h003, 10'h003,24'h000000,10'h000,0,0, 14,3);
    step(0,1,1,0,10'h000, 10'h003,24'hE00003,10'h004,1,1, 15,3);
    // reset while halted
    step(1,1,1,0,10'h000, 10'h000,24'h000000,10'h000,0,0, 0,0);
    step(0,1,1,0,10'h000, 10'h001,24'h000001,10'h001,1,0, 1,0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline; directly upstream of the hazard/stall unit and decode.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction into IF/ID.
- Obeys PC_WriteEn/IFID_WriteEn from the stall unit, branch flushes from EX, and freezes on the END opcode.

Parameters:
PC_W, 10, PC width in bits (word address into instruction memory)
INSTR_W, 24, instruction width; opcode = Instr[INSTR_W-1 -: 3]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
PC_WriteEn  input  1  1 = PC may advance; 0 = hold PC
IFID_WriteEn  input  1  1 = IF/ID may load; 0 = hold IF/ID
Branch_Taken  input  1  branch resolved taken in EX; redirect and flush
Branch_Target  input  PC_W  redirect address
Instr_In  input  INSTR_W  instruction memory read data for Instr_Addr (asynchronous read, same cycle)
Instr_Addr  output  PC_W  current PC (register output, combinational to memory)
IFID_Instr  output  INSTR_W  latched instruction to ID (drives ID_Op/ID_rs/ID_rt)
IFID_PC1  output  PC_W  PC+1 of latched instruction
IFID_Valid  output  1  1 = IF/ID holds a real instruction
Halted  output  1  1 = END latched, fetch frozen
Fetch_Count  output  32  fetched-instruction counter (optional feature)
Stall_Count  output  32  stall-cycle counter (optional feature)

Behaviour:
- Reset (synchronous, highest priority):
  - PC=RESET_PC.
  - IFID_Instr=0 (all-zero = NOP bubble), IFID_PC1=0, IFID_Valid=0.
  - State=RUN, Halted=0, counters=0.
- States: RUN, HALT. Halted=1 exactly when state=HALT.
- RUN, per-edge priority:
  1. Branch_Taken=1:
     - PC<=Branch_Target.
     - IF/ID<=bubble (Instr=0, PC1=0, Valid=0), regardless of either write enable.
     - Branch beats a simultaneous stall.
  2. Otherwise, PC and IF/ID update independently:
     - PC_WriteEn=1: PC<=PC+1, modulo 2^PC_W (all-ones wraps to 0). PC_WriteEn=0: PC holds.
     - IFID_WriteEn=1: IFID_Instr<=Instr_In, IFID_PC1<=PC+1 (wrapped), IFID_Valid<=1. IFID_WriteEn=0: IF/ID holds all fields.
  3. Halt entry: if IF/ID loads this cycle and opcode(Instr_In)==3'b111, next state=HALT and PC holds even if PC_WriteEn=1.
- Latency: Instr_In at PC=n appears on IFID_Instr one cycle later; the first valid IF/ID occurs on the 1st edge after reset release.
- HALT:
  - PC, IF/ID and counters frozen; Halted=1.
  - Enables are ignored.
  - Branch_Taken=1 means the END was on a wrong path: PC<=Branch_Target, IF/ID<=bubble, state<=RUN, Halted<=0.
  - Otherwise only reset exits HALT.
- Reset asserted mid-stall, mid-branch or in HALT: reset wins on that edge.
- No combinational path from any input to any output except through the registers (Instr_Addr=PC register).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Fetch_Count increments on each RUN-state edge where IF/ID loads a valid instruction.
  - Stall_Count increments on each RUN-state edge where Branch_Taken=0 and PC_WriteEn=0.
  - Both are 32-bit, wrap at 2^32, clear on reset, and freeze in HALT.
- Undefined: both ports driven constant 0 and no counter flops are synthesized.

Test Plan:
- Reset 2 cycles, enables=1, memory returns Instr=addr+1 → IFID_Instr=1,2,3 on successive edges, IFID_PC1=1,2,3, Instr_Addr=1,2,3, IFID_Valid=1 from first edge.
- At PC=5 drive PC_WriteEn=IFID_WriteEn=0 for 2 cycles → Instr_Addr stays 5, IF/ID unchanged, Stall_Count=2 (macro on), then resume to PC=6.
- At PC=8 with stall active, Branch_Taken=1, Target=0x040 → next Instr_Addr=0x040, IFID_Valid=0, IFID_Instr=0; following edge loads mem[0x040].
- PC_W=10, PC=0x3FF, normal fetch → Instr_Addr=0x000, IFID_PC1=0x000.
- mem[3]=opcode 3'b111 → after its load Halted=1, Instr_Addr frozen at 3 for 10 cycles despite enables=1; then Branch_Taken=1, Target=0x010 → Halted=0, Instr_Addr=0x010, IFID_Valid=0.
- In HALT assert reset 1 cycle → Instr_Addr=RESET_PC, Halted=0, IFID_Valid=0, Fetch_Count=0.
